// File: rtl/cpu_core_axi_master_if.sv
// AXI4-Lite bus bundle between the cpu_core_axi_master initiator and the
// memory/peripheral interconnect.
interface cpu_core_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/cpu_core_axi_master.sv
// Single-outstanding AXI4-Lite initiator driven by the core's load/store port.
// Optional bus watchdog enabled by defining CPU_CORE_AXI_MASTER_TIMEOUT_EN.
module cpu_core_axi_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            CCLK,
  input  logic                            CRST,
  input  logic                            MEM_REQ,
  input  logic                            MEM_WE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   MEM_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   MEM_WDATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] MEM_WSTRB,
  output logic                            MEM_BUSY,
  output logic                            MEM_DONE,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   MEM_RDATA,
  output logic                            MEM_ERR,
  cpu_core_axi_master_if.master           m_axi
);

  if (C_M_AXI_DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("cpu_core_axi_master: data width must be 32 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, DONE} state_t;

  state_t                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, err_q, err_d;

`ifdef CPU_CORE_AXI_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge CCLK or posedge CRST) begin
    if (CRST) begin
      state_q   <= IDLE;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
`ifdef CPU_CORE_AXI_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      err_q     <= err_d;
`ifdef CPU_CORE_AXI_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Every bus control output is a register, so the next-state logic also
  // computes the next value of each VALID/READY and payload register.
  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (MEM_REQ) begin
          if (MEM_WE) begin
            awaddr_d  = MEM_ADDR;
            wdata_d   = MEM_WDATA;
            wstrb_d   = MEM_WSTRB;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            araddr_d  = MEM_ADDR;
            arvalid_d = 1'b1;
            state_d   = READ;
          end
        end
      end
      WRITE: begin
        // AW and W complete independently; move on once neither is pending.
        awvalid_d = awvalid_q & ~m_axi.awready;
        wvalid_d  = wvalid_q & ~m_axi.wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end
      WRESP: begin
        if (m_axi.bvalid && bready_q) begin
          err_d    = (m_axi.bresp != 2'b00);
          bready_d = 1'b0;
          state_d  = DONE;
        end
      end
      READ: begin
        if (arvalid_q && m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (m_axi.rvalid && rready_q) begin
          rdata_d  = m_axi.rdata;
          err_d    = (m_axi.rresp != 2'b00);
          rready_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef CPU_CORE_AXI_MASTER_TIMEOUT_EN
    cnt_d = (state_q == IDLE || state_q == DONE) ? '0 : cnt_q + 1'b1;
    // Watchdog abandons the bus outright, even in the middle of a handshake.
    if (state_q != IDLE && state_q != DONE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      err_d     = 1'b1;
      if (state_q == READ || state_q == RDATA)
        rdata_d = 32'hDEAD_BEEF;
      state_d   = DONE;
    end
`endif
  end

  assign MEM_BUSY  = (state_q != IDLE) && (state_q != DONE);
  assign MEM_DONE  = (state_q == DONE);
  assign MEM_RDATA = rdata_q;
  assign MEM_ERR   = err_q;

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_cpu_core_axi_master.sv
// Directed self-checking bench for cpu_core_axi_master; the slave side of the
// bus is driven step by step so every handshake cycle is known in advance.
module tb_cpu_core_axi_master;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_busy;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int compared   = 0;
  int mismatched = 0;
  int aw_hs      = 0;
  int ar_hs      = 0;
  int done_cnt   = 0;

  cpu_core_axi_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  cpu_core_axi_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .CCLK     (clk),
    .CRST     (rst),
    .MEM_REQ  (mem_req),
    .MEM_WE   (mem_we),
    .MEM_ADDR (mem_addr),
    .MEM_WDATA(mem_wdata),
    .MEM_WSTRB(mem_wstrb),
    .MEM_BUSY (mem_busy),
    .MEM_DONE (mem_done),
    .MEM_RDATA(mem_rdata),
    .MEM_ERR  (mem_err),
    .m_axi    (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake and completion counters used to prove one transaction per DONE.
  always @(posedge clk) begin
    if (!rst) begin
      if (axi.awvalid && axi.awready) aw_hs++;
      if (axi.arvalid && axi.arready) ar_hs++;
      if (mem_done) done_cnt++;
    end
  end

  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
    mem_req   = req;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setSlave(input logic awr, input logic wr, input logic arr,
                          input logic bv, input logic rv);
    axi.awready = awr;
    axi.wready  = wr;
    axi.arready = arr;
    axi.bvalid  = bv;
    axi.rvalid  = rv;
  endtask

  int ar_base, aw_base, done_base;
  logic exp_we;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setSlave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    axi.bresp = 2'b00;
    axi.rresp = 2'b00;
    axi.rdata = 32'h0;

    // Reset state
    repeat (2) nextCycle();
    checkOutput("rst_busy", mem_busy, 0);
    checkOutput("rst_done", mem_done, 0);
    checkOutput("rst_err", mem_err, 0);
    checkOutput("rst_rdata", mem_rdata, 0);
    checkOutput("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
    checkOutput("rst_readys", {axi.bready, axi.rready}, 0);
    checkOutput("rst_addr", {axi.awaddr, axi.araddr}, 0);
    checkOutput("rst_wpayload", {axi.wdata, axi.wstrb}, 0);
    rst = 1'b0;

    // Zero-wait read of 0x100
    $display("[TB] read, zero-wait slave");
    axi.arready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd_c0_busy", mem_busy, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd_c1_arvalid", axi.arvalid, 1);
    checkOutput("rd_c1_araddr", axi.araddr, 32'h100);
    checkOutput("rd_c1_arprot", axi.arprot, 0);
    checkOutput("rd_c1_busy", mem_busy, 1);
    nextCycle();
    axi.rvalid = 1'b1;
    axi.rdata  = 32'h1234_5678;
    axi.rresp  = 2'b00;
    @(negedge clk);
    checkOutput("rd_c2_rready", axi.rready, 1);
    checkOutput("rd_c2_arvalid", axi.arvalid, 0);
    checkOutput("rd_c2_done", mem_done, 0);
    nextCycle();
    axi.rvalid = 1'b0;
    @(negedge clk);
    checkOutput("rd_c3_done", mem_done, 1);
    checkOutput("rd_c3_busy", mem_busy, 0);
    checkOutput("rd_c3_rdata", mem_rdata, 32'h1234_5678);
    checkOutput("rd_c3_err", mem_err, 0);
    checkOutput("rd_c3_rready", axi.rready, 0);
    nextCycle();
    axi.arready = 1'b0;
    @(negedge clk);
    checkOutput("rd_c4_done", mem_done, 0);
    checkOutput("rd_c4_rdata_held", mem_rdata, 32'h1234_5678);

    // Write where WREADY arrives three cycles before AWREADY
    $display("[TB] write, W before AW");
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'b0011);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    axi.wready = 1'b1;
    @(negedge clk);
    checkOutput("wr_c1_valids", {axi.awvalid, axi.wvalid}, 2'b11);
    checkOutput("wr_c1_awaddr", axi.awaddr, 32'h200);
    checkOutput("wr_c1_wdata", axi.wdata, 32'hCAFE_F00D);
    checkOutput("wr_c1_wstrb", axi.wstrb, 4'b0011);
    checkOutput("wr_c1_awprot", axi.awprot, 0);
    nextCycle();
    axi.wready = 1'b0;
    @(negedge clk);
    checkOutput("wr_c2_valids", {axi.awvalid, axi.wvalid}, 2'b10);
    checkOutput("wr_c2_bready", axi.bready, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("wr_c3_valids", {axi.awvalid, axi.wvalid}, 2'b10);
    checkOutput("wr_c3_awaddr_stable", axi.awaddr, 32'h200);
    nextCycle();
    axi.awready = 1'b1;
    @(negedge clk);
    checkOutput("wr_c4_awvalid", axi.awvalid, 1);
    checkOutput("wr_c4_bready", axi.bready, 0);
    nextCycle();
    axi.awready = 1'b0;
    axi.bvalid  = 1'b1;
    axi.bresp   = 2'b00;
    @(negedge clk);
    checkOutput("wr_c5_awvalid", axi.awvalid, 0);
    checkOutput("wr_c5_bready", axi.bready, 1);
    checkOutput("wr_c5_done", mem_done, 0);
    nextCycle();
    axi.bvalid = 1'b0;
    @(negedge clk);
    checkOutput("wr_c6_done", mem_done, 1);
    checkOutput("wr_c6_err", mem_err, 0);
    checkOutput("wr_c6_bready", axi.bready, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("wr_c7_done", mem_done, 0);

    // SLVERR read, then an OKAY write clears the error
    $display("[TB] error read followed by clean write");
    axi.arready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nextCycle();
    axi.rvalid = 1'b1;
    axi.rdata  = 32'hBAD0_0001;
    axi.rresp  = 2'b10;
    nextCycle();
    axi.rvalid = 1'b0;
    axi.rresp  = 2'b00;
    axi.arready = 1'b0;
    @(negedge clk);
    checkOutput("slverr_done", mem_done, 1);
    checkOutput("slverr_err", mem_err, 1);
    nextCycle();
    setSlave(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0208, 32'h0000_00FF, 4'b1111);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("clr_c1_err_held", mem_err, 1);
    nextCycle();
    axi.bvalid = 1'b1;
    axi.bresp  = 2'b00;
    nextCycle();
    axi.bvalid = 1'b0;
    @(negedge clk);
    checkOutput("clr_c3_done", mem_done, 1);
    checkOutput("clr_c3_err", mem_err, 0);
    nextCycle();

    // MEM_REQ held high with alternating WE, unaligned address, zero strobes
    $display("[TB] back-to-back requests");
    setSlave(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    axi.rdata = 32'h5A5A_0F0F;
    aw_base   = aw_hs;
    ar_base   = ar_hs;
    done_base = done_cnt;
    applyStimulus(1'b1, 1'b1, 32'h0000_0203, 32'h1111_2222, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      exp_we = (i % 2 == 0);
      @(negedge clk);
      checkOutput($sformatf("b2b%0d_c0_busy", i), mem_busy, 0);
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("b2b%0d_c1_aw", i), axi.awvalid, exp_we);
      checkOutput($sformatf("b2b%0d_c1_ar", i), axi.arvalid, !exp_we);
      if (exp_we) begin
        checkOutput($sformatf("b2b%0d_c1_wstrb0", i), {axi.wvalid, axi.wstrb}, 5'b10000);
        checkOutput($sformatf("b2b%0d_c1_awaddr", i), axi.awaddr, 32'h203);
      end else begin
        checkOutput($sformatf("b2b%0d_c1_araddr", i), axi.araddr, 32'h203);
      end
      nextCycle();
      mem_we = !exp_we;
      @(negedge clk);
      checkOutput($sformatf("b2b%0d_c2_busy", i), mem_busy, 1);
      checkOutput($sformatf("b2b%0d_c2_valids", i), {axi.awvalid, axi.wvalid, axi.arvalid}, 0);
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("b2b%0d_c3_done", i), mem_done, 1);
      if (!exp_we)
        checkOutput($sformatf("b2b%0d_c3_rdata", i), mem_rdata, 32'h5A5A_0F0F);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setSlave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("b2b_aw_count", aw_hs - aw_base, 2);
    checkOutput("b2b_ar_count", ar_hs - ar_base, 2);
    checkOutput("b2b_done_count", done_cnt - done_base, 4);
    nextCycle();

    // Reset pulsed while ARVALID waits for ARREADY
    $display("[TB] reset during read address phase");
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("rstmid_arvalid_before", axi.arvalid, 1);
    done_base = done_cnt;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_arvalid_async", axi.arvalid, 0);
    checkOutput("rstmid_busy", mem_busy, 0);
    checkOutput("rstmid_rdata_cleared", mem_rdata, 0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
    nextCycle();
    @(negedge clk);
    checkOutput("rstmid_no_done", done_cnt - done_base, 0);
    checkOutput("rstmid_idle", {mem_busy, mem_done, axi.arvalid}, 0);
    nextCycle();
    axi.arready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_0304, 32'h0, 4'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("post_rst_araddr", axi.araddr, 32'h304);
    nextCycle();
    axi.rvalid = 1'b1;
    axi.rdata  = 32'h0000_BEEF;
    nextCycle();
    axi.rvalid  = 1'b0;
    axi.arready = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_done", mem_done, 1);
    checkOutput("post_rst_rdata", mem_rdata, 32'h0000_BEEF);
    checkOutput("post_rst_err", mem_err, 0);
    nextCycle();

`ifdef CPU_CORE_AXI_MASTER_TIMEOUT_EN
    // Watchdog: ARREADY never arrives, limit of 16 cycles
    $display("[TB] read timeout");
    applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 16) begin
        checkOutput("to_c16_done", mem_done, 0);
        checkOutput("to_c16_arvalid", axi.arvalid, 1);
      end
      nextCycle();
    end
    @(negedge clk);
    checkOutput("to_c17_done", mem_done, 1);
    checkOutput("to_c17_err", mem_err, 1);
    checkOutput("to_c17_rdata", mem_rdata, 32'hDEAD_BEEF);
    checkOutput("to_c17_arvalid", axi.arvalid, 0);
    nextCycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_core_axi_master.md
Name: cpu_core_axi_master

Overview:
- AXI4-Lite initiator in the CCLK domain that turns the core's simple load/store request interface into single-beat AXI4-Lite read/write transactions toward memory/peripherals.
- It is the master-side counterpart of the register-readback controller slave.
- One outstanding transaction at a time.
- Completion is reported to the core with a one-cycle pulse plus read data and error status.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width; MEM_ADDR width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
- TIMEOUT_CYCLES, 1024, watchdog limit in CCLK cycles (used only with the optional feature).

Ports:
- CCLK  in  1  clock (also the AXI clock).
- CRST  in  1  asynchronous active-high reset.
- MEM_REQ  in  1  request strobe; sampled only when MEM_BUSY=0.
- MEM_WE  in  1  1=write, 0=read.
- MEM_ADDR  in  C_M_AXI_ADDR_WIDTH  byte address.
- MEM_WDATA  in  32  write data.
- MEM_WSTRB  in  4  byte enables (write only).
- MEM_BUSY  out  1  transaction in flight.
- MEM_DONE  out  1  one-cycle completion pulse.
- MEM_RDATA  out  32  read data; valid with MEM_DONE on reads, then held.
- MEM_ERR  out  1  valid with MEM_DONE; 1 if RRESP/BRESP != OKAY (or on timeout).
- M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in: write address channel; AWPROT=3'b000.
- M_AXI_WDATA/WSTRB/WVALID out, WREADY in: write data channel.
- M_AXI_BRESP/BVALID in, BREADY out: write response channel.
- M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in: read address channel; ARPROT=3'b000.
- M_AXI_RDATA/RRESP/RVALID in, RREADY out: read data channel.

Behaviour:
- Reset (CRST high, asynchronous):
  - All VALID/READY outputs, MEM_BUSY, MEM_DONE and MEM_ERR are 0.
  - MEM_RDATA, AWADDR, ARADDR, WDATA and WSTRB are 0.
  - State is IDLE.
- Reset asserted mid-transaction aborts immediately: all VALIDs drop and the core receives no DONE. The interconnect must be reset alongside.
- States: IDLE, WRITE, WRESP, READ, RDATA, DONE.
- IDLE:
  - On MEM_REQ=1, capture address, data and strobe into registers; MEM_BUSY=1 on the next edge.
  - WE=1: go to WRITE with AWVALID=WVALID=1.
  - WE=0: go to READ with ARVALID=1.
- WRITE:
  - AWVALID drops the cycle after AW handshake (AWVALID&AWREADY); WVALID drops independently after the W handshake.
  - Both handshakes in the same cycle are allowed.
  - When both are done, go to WRESP with BREADY=1.
  - AW/W payload is stable while VALID is high.
  - VALID never deasserts without its handshake.
- WRESP: on BVALID&BREADY, set MEM_ERR=(BRESP!=2'b00), BREADY=0, go to DONE.
- READ: on ARVALID&ARREADY, ARVALID=0, RREADY=1, go to RDATA.
- RDATA: on RVALID&RREADY, latch MEM_RDATA=RDATA, MEM_ERR=(RRESP!=2'b00), RREADY=0, go to DONE.
- DONE:
  - MEM_DONE=1 for exactly one cycle, MEM_BUSY=0 in that same cycle, return to IDLE.
  - MEM_ERR holds until the next DONE.
- Latency with a zero-wait slave (READY high, response the following cycle):
  - Read: REQ at cycle 0, ARVALID at 1, RVALID at 2, MEM_DONE at 3.
  - Write: REQ at cycle 0, AW/W at 1, BVALID at 2, MEM_DONE at 3.
- MEM_REQ while BUSY=1 is ignored; the core must hold or re-issue.
- MEM_REQ in the DONE cycle is ignored; it is accepted the following cycle.
- MEM_ADDR is passed to the bus unmodified; low bits are not forced to zero.
- Write with MEM_WSTRB=0 is still issued on the bus.

Optional Feature:
- Macro: CPU_CORE_AXI_MASTER_TIMEOUT_EN.
- Defined:
  - A cycle counter resets on entry to WRITE/READ and increments each cycle in WRITE, WRESP, READ and RDATA.
  - When it reaches TIMEOUT_CYCLES-1, go to DONE with MEM_ERR=1. MEM_RDATA=32'hDEAD_BEEF on reads.
  - All VALID/READY outputs drop that cycle, even mid-handshake; the bus is considered broken.
- Not defined: no counter; the FSM waits indefinitely.

Test Plan:
- Read, zero-wait slave returning RDATA=32'h1234_5678, RRESP=OKAY at ADDR 32'h0000_0100 -> ARADDR=32'h100, MEM_DONE at cycle 3, MEM_RDATA=32'h1234_5678, MEM_ERR=0.
- Write WDATA=32'hCAFE_F00D, WSTRB=4'b0011, ADDR 32'h200; slave asserts WREADY 3 cycles before AWREADY -> WVALID drops first, AWVALID holds until AWREADY, BREADY only after both, one MEM_DONE, MEM_ERR=0.
- Read with RRESP=2'b10 (SLVERR) -> MEM_DONE with MEM_ERR=1; the next OKAY write clears MEM_ERR=0.
- MEM_REQ held high continuously with alternating WE -> exactly one bus transaction per DONE, none started during BUSY, back-to-back spacing of 4 cycles.
- CRST pulsed while ARVALID=1 awaiting ARREADY -> ARVALID=0 asynchronously, no MEM_DONE, the next request behaves normally.
- With CPU_CORE_AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts ARREADY -> MEM_DONE at cycle 17 after REQ, MEM_ERR=1, MEM_RDATA=32'hDEADBEEF, ARVALID=0.
